// File: rtl/mxn_seq_encoder.sv
// Sequential multi-hit priority encoder: walks every set bit of a captured request vector,
// one index per beat. Optional out_remaining popcount port via MXN_SEQ_ENCODER_COUNT_EN.
module mxn_seq_encoder #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PRIORITY_TYPE = 0,
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_hit,
  output logic                  out_last
`ifdef MXN_SEQ_ENCODER_COUNT_EN
  ,
  output logic [$clog2(DATA_WIDTH+1)-1:0] out_remaining
`endif
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pending_q;
  logic                  zero_q;

  logic [DATA_WIDTH-1:0] sel_mask;
  logic [IDX_W-1:0]      sel_idx;
  logic                  found;
  logic                  one_left;
  logic                  scan;

  // Maps scan step i to a bit position so the first hit found is the highest-priority one.
  function automatic int unsigned scan_pos(int unsigned i);
    return (PRIORITY_TYPE == 0) ? i : (DATA_WIDTH - 1 - i);
  endfunction

  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (!found && pending_q[scan_pos(i)]) begin
        found                = 1'b1;
        sel_idx              = IDX_W'(scan_pos(i));
        sel_mask[scan_pos(i)] = 1'b1;
      end
    end
  end

  assign one_left  = (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);
  assign scan      = (state_q == StScan);

  assign out_valid = scan;
  assign out_hit   = scan & ~zero_q;
  assign out_last  = scan & (zero_q | one_left);
  assign out_index = scan ? sel_idx : '0;
  assign in_ready  = ~scan | (out_ready & out_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else if (in_valid && in_ready) begin
      // Covers both idle capture and back-to-back capture on the last beat.
      state_q   <= StScan;
      pending_q <= in_data;
      zero_q    <= (in_data == '0);
    end else if (scan && out_ready) begin
      if (out_last) begin
        state_q   <= StIdle;
        pending_q <= '0;
        zero_q    <= 1'b0;
      end else begin
        pending_q <= pending_q & ~sel_mask;
      end
    end
  end

`ifdef MXN_SEQ_ENCODER_COUNT_EN
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic [CNT_W-1:0] pop_cnt;

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      pop_cnt = pop_cnt + CNT_W'(pending_q[i]);
    end
  end

  assign out_remaining = scan ? pop_cnt : '0;
`endif

endmodule

// File: doc/mxn_seq_encoder.md
Name: mxn_seq_encoder

Overview:
- Sequential multi-hit priority encoder: accepts one DATA_WIDTH-bit request vector per transaction through a valid/ready input handshake.
- Emits the index of every set bit, one beat per index, in priority order (LSB-first or MSB-first), through a valid/ready output handshake.
- Successor to the single-hit combinational encoder. Used where all asserted requests must be serviced, not just the winner (interrupt drain, free-list scan, bitmap walk).

Parameters:
- DATA_WIDTH, 8, width of request vector; legal range >= 1.
- PRIORITY_TYPE, 0, 0: lowest set index emitted first; 1: highest set index emitted first.
- IDX_W, (DATA_WIDTH>1 ? $clog2(DATA_WIDTH) : 1), index width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a new vector this cycle.
- in_data  input  DATA_WIDTH  request vector.
- out_valid  output  1  out_index/out_hit/out_last valid.
- out_ready  input  1  downstream accepts current beat.
- out_index  output  IDX_W  index of current highest-priority pending bit.
- out_hit  output  1  1: out_index refers to a set bit; 0: captured vector was all-zero.
- out_last  output  1  current beat is final beat of the transaction.

Behaviour:
- Internal state: FSM {IDLE, SCAN}; pending register [DATA_WIDTH]; zero_flag register.
- Reset (rst_n=0 at rising edge): state=IDLE, pending=0, zero_flag=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_index=0, out_hit=0, out_last=0.
  - Reset mid-SCAN discards the remaining bits; no further beats from that vector.
- in_ready = (state==IDLE) | (state==SCAN & out_ready & out_last).
  - Combinational from state/pending/out_ready; no dependence on in_valid.
- Capture: in_valid & in_ready at edge N.
  - pending <= in_data; zero_flag <= (in_data==0); state <= SCAN.
  - First beat visible on out_valid in cycle N+1 (1-cycle latency).
- SCAN outputs (all derived from registers; out_valid=1 throughout SCAN):
  - out_index = priority-selected set bit of pending: lowest index if PRIORITY_TYPE=0, highest if 1.
  - out_hit = ~zero_flag.
  - out_last = zero_flag | (exactly one bit of pending set).
- Beat accept (out_valid & out_ready):
  - Not last: clear pending[out_index]; stay SCAN.
  - Last, no new capture in the same cycle: state <= IDLE, pending <= 0, zero_flag <= 0.
  - Last with simultaneous capture (back-to-back): new vector loaded as in Capture. Its first beat is presented the next cycle with no idle bubble.
- out_valid & ~out_ready: all outputs and pending held stable; out_index must not change while stalled.
- All-zero vector: exactly one beat; out_hit=0, out_index=0, out_last=1.
- All-ones vector: exactly DATA_WIDTH beats, indices in strict priority order, out_last only on the final beat.
- DATA_WIDTH=1: a set vector gives one beat (index 0, hit=1, last=1); a clear vector gives one beat with hit=0.
- Throughput: one index per cycle when out_ready held high; a transaction of K set bits occupies K cycles (1 if K=0).
- in_data is ignored when in_ready=0; upstream must hold in_valid/in_data until accepted.

Optional Feature:
- Macro: MXN_SEQ_ENCODER_COUNT_EN.
- Defined: adds output port out_remaining [$clog2(DATA_WIDTH+1)].
  - Value = popcount(pending) during SCAN, including the current beat. It is 1 on the last hit beat and 0 on a zero-vector beat.
  - Forced to 0 in IDLE and after reset.
  - Held stable under stall.
- Not defined: port absent, no popcount logic; all other behaviour identical.

Test Plan:
- Reset, then DATA_WIDTH=8, PRIORITY_TYPE=0, in_data=8'b1010_0100, out_ready=1 → beats index 2,5,7; out_last only on 7; in_ready=0 during first two beats; 3 beats in cycles N+1..N+3.
- Same vector with PRIORITY_TYPE=1 → beats 7,5,2; last on 2. With COUNT_EN, out_remaining reads 3,2,1.
- in_data=8'h00 → single beat: out_hit=0, out_index=0, out_last=1; block then returns to IDLE.
- Back-to-back: 8'h81, then 8'h10 held on in_valid → beats 0,7 (last), then 4 (last) in the immediately following cycle, with no idle cycle between transactions.
- Stall: in_data=8'hFF, out_ready toggled 1,0,0,1,... → out_index held across stalled cycles; exactly 8 beats 0..7; no index skipped or repeated.
- Reset mid-operation: in_data=8'hF0, accept one beat (index 4), assert rst_n=0 for one cycle → out_valid=0 and in_ready=1 the next cycle; indices 5..7 never emitted.
